// File: rtl/com_pkg.sv
// Shared fetch-stage types: FSM state encoding, BTB entry layout and helpers.
package com_pkg;

    localparam int unsigned ADR_W      = 32;
    localparam int unsigned INSN_BYTES = 4;
    localparam int unsigned CTR_W      = 2;

    typedef enum logic [0:0] {
        FETCH     = 1'b0,
        MISS_WAIT = 1'b1
    } fetch_state_e;

    // Tag is stored zero-extended to the full address width.
    typedef struct packed {
        logic             valid;
        logic [ADR_W-1:0] tag;
        logic [ADR_W-1:0] target;
        logic [CTR_W-1:0] ctr;
    } btb_entry_t;

    // Saturating two-bit direction counter step.
    function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] ctr,
                                                  input logic             up);
        logic [CTR_W-1:0] res;
        res = ctr;
        if (up && (ctr != 2'd3)) begin
            res = ctr + 2'd1;
        end else if (!up && (ctr != 2'd0)) begin
            res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer: combinational lookup, single-port
// registered update; a same-cycle lookup sees the pre-update contents.
module fetch_btb
    import com_pkg::*;
#(
    parameter int unsigned ADR_WIDTH   = 32,
    parameter int unsigned BTB_ENTRIES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADR_WIDTH-1:0] lookup_pc,
    output logic                 taken_c,
    output logic [ADR_WIDTH-1:0] target_c,
    input  logic                 upd_valid,
    input  logic [ADR_WIDTH-1:0] upd_pc,
    input  logic [ADR_WIDTH-1:0] upd_target,
    input  logic                 upd_taken
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);

    btb_entry_t       btb_q [BTB_ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [ADR_W-1:0] rd_tag;
    btb_entry_t       rd_entry;

    logic [IDX_W-1:0] wr_idx;
    logic [ADR_W-1:0] wr_tag;
    btb_entry_t       wr_old;
    btb_entry_t       wr_entry;
    logic             wr_hit;
    logic             wr_en;

    // Instruction-aligned addresses: the byte offset bits never index or tag.
    logic             unused_lsbs;
    assign unused_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

    // Lookup path
    always_comb begin
        rd_idx   = lookup_pc[IDX_W+1:2];
        rd_tag   = ADR_W'(lookup_pc[ADR_WIDTH-1:IDX_W+2]);
        rd_entry = btb_q[rd_idx];
        taken_c  = rd_entry.valid && (rd_entry.tag == rd_tag) && (rd_entry.ctr >= 2'd2);
        target_c = ADR_WIDTH'(rd_entry.target);
    end

    // Update path: train on hit, allocate weakly-taken only on a taken miss
    always_comb begin
        wr_idx   = upd_pc[IDX_W+1:2];
        wr_tag   = ADR_W'(upd_pc[ADR_WIDTH-1:IDX_W+2]);
        wr_old   = btb_q[wr_idx];
        wr_hit   = wr_old.valid && (wr_old.tag == wr_tag);
        wr_entry = wr_old;
        wr_en    = 1'b0;
        if (upd_valid) begin
            if (wr_hit) begin
                wr_en        = 1'b1;
                wr_entry.ctr = ctr_step(wr_old.ctr, upd_taken);
                if (upd_taken) begin
                    wr_entry.target = ADR_W'(upd_target);
                end
            end else if (upd_taken) begin
                wr_en           = 1'b1;
                wr_entry.valid  = 1'b1;
                wr_entry.tag    = wr_tag;
                wr_entry.target = ADR_W'(upd_target);
                wr_entry.ctr    = 2'd2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                btb_q[i].valid <= 1'b0;
            end
        end else if (wr_en) begin
            btb_q[wr_idx] <= wr_entry;
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch stage PC generator: one i-cache request per cycle, miss wait,
// decode back-pressure, backend redirect and BTB-driven next-PC prediction.
module fetch_pc_gen
    import com_pkg::*;
#(
    parameter int unsigned          ADR_WIDTH    = 32,
    parameter logic [ADR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned          BTB_ENTRIES  = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [ADR_WIDTH-1:0] address,
    output logic                 req_valid,
    input  logic                 data_valid,
    input  logic                 cache_miss,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [ADR_WIDTH-1:0] redirect_pc,
    output logic                 req_kill,
    output logic [ADR_WIDTH-1:0] predicted_next_adr,
    output logic                 branch_jump,
    input  logic                 upd_valid,
    input  logic [ADR_WIDTH-1:0] upd_pc,
    input  logic [ADR_WIDTH-1:0] upd_target,
    input  logic                 upd_taken
);

    fetch_state_e         state_q;
    fetch_state_e         state_nxt;
    logic [ADR_WIDTH-1:0] pc_q;
    logic [ADR_WIDTH-1:0] nxt_pc;
    logic                 pred_taken;
    logic [ADR_WIDTH-1:0] pred_target;

    fetch_btb #(
        .ADR_WIDTH   (ADR_WIDTH),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk        (clk),
        .rst_n      (rst_n),
        .lookup_pc  (pc_q),
        .taken_c    (pred_taken),
        .target_c   (pred_target),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_target (upd_target),
        .upd_taken  (upd_taken)
    );

    assign address = pc_q;
    assign nxt_pc  = pred_taken ? pred_target : pc_q + ADR_WIDTH'(INSN_BYTES);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic; redirect overrides any pending miss
    always_comb begin
        state_nxt = state_q;
        if (redirect_valid) begin
            state_nxt = FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (cache_miss) begin
                        state_nxt = MISS_WAIT;
                    end
                end
                MISS_WAIT: begin
                    if (data_valid && !cache_miss) begin
                        state_nxt = FETCH;
                    end
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    // Request/kill outputs, both silenced while reset is held
    always_comb begin
        req_valid = 1'b0;
        req_kill  = 1'b0;
        if (rst_n) begin
            req_kill  = redirect_valid;
            req_valid = (state_q == FETCH) && !stall && !cache_miss && !redirect_valid;
        end
    end

    // PC advances on issue or jumps on redirect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_VECTOR;
        end else if (redirect_valid) begin
            pc_q <= redirect_pc;
        end else if (req_valid) begin
            pc_q <= nxt_pc;
        end
    end

    // Prediction is captured at issue so it lines up with the returned data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            predicted_next_adr <= '0;
            branch_jump        <= 1'b0;
        end else if (req_valid) begin
            predicted_next_adr <= nxt_pc;
            branch_jump        <= pred_taken;
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_fetch_pc_gen;

    localparam int unsigned AW   = 32;
    localparam int unsigned NE   = 64;
    localparam int unsigned IDXW = 6;
    localparam logic [31:0] RV   = 32'h0000_0000;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] address;
    logic          req_valid;
    logic          data_valid;
    logic          cache_miss;
    logic          stall;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          req_kill;
    logic [AW-1:0] predicted_next_adr;
    logic          branch_jump;
    logic          upd_valid;
    logic [AW-1:0] upd_pc;
    logic [AW-1:0] upd_target;
    logic          upd_taken;

    fetch_pc_gen #(
        .ADR_WIDTH    (AW),
        .RESET_VECTOR (RV),
        .BTB_ENTRIES  (NE)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .address            (address),
        .req_valid          (req_valid),
        .data_valid         (data_valid),
        .cache_miss         (cache_miss),
        .stall              (stall),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .req_kill           (req_kill),
        .predicted_next_adr (predicted_next_adr),
        .branch_jump        (branch_jump),
        .upd_valid          (upd_valid),
        .upd_pc             (upd_pc),
        .upd_target         (upd_target),
        .upd_taken          (upd_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: PC, waiting-for-miss flag, held prediction, BTB table
    bit          m_valid [NE];
    logic [31:0] m_tag   [NE];
    logic [31:0] m_tgt   [NE];
    int          m_ctr   [NE];
    logic [31:0] m_pc    = RV;
    logic [31:0] m_pred  = '0;
    bit          m_bj    = 1'b0;
    bit          m_wait  = 1'b0;

    bit          e_taken;
    logic [31:0] e_nxt;
    bit          e_rv;
    bit          e_kill;

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % NE);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a >> (2 + IDXW);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic compute_exp();
        int i;
        i       = idx_of(m_pc);
        e_taken = m_valid[i] && (m_tag[i] == tag_of(m_pc)) && (m_ctr[i] >= 2);
        e_nxt   = e_taken ? m_tgt[i] : m_pc + 32'd4;
        e_rv    = rst_n && !m_wait && !stall && !cache_miss && !redirect_valid;
        e_kill  = rst_n && redirect_valid;
    endtask

    // Inputs were driven at posedge+1; compare mid-cycle against the model
    task automatic step_check();
        #3;
        compute_exp();
        chk("address",            address,            m_pc);
        chk("req_valid",          32'(req_valid),     32'(e_rv));
        chk("req_kill",           32'(req_kill),      32'(e_kill));
        chk("predicted_next_adr", predicted_next_adr, m_pred);
        chk("branch_jump",        32'(branch_jump),   32'(m_bj));
    endtask

    task automatic model_advance();
        int i;
        if (!rst_n) begin
            m_pc   = RV;
            m_wait = 1'b0;
            m_pred = '0;
            m_bj   = 1'b0;
            for (int k = 0; k < int'(NE); k++) m_valid[k] = 1'b0;
        end else begin
            if (redirect_valid) begin
                m_pc   = redirect_pc;
                m_wait = 1'b0;
            end else if (e_rv) begin
                m_pc   = e_nxt;
                m_pred = e_nxt;
                m_bj   = e_taken;
            end else if (!m_wait && cache_miss) begin
                m_wait = 1'b1;
            end else if (m_wait && data_valid && !cache_miss) begin
                m_wait = 1'b0;
            end
            if (upd_valid) begin
                i = idx_of(upd_pc);
                if (m_valid[i] && m_tag[i] == tag_of(upd_pc)) begin
                    if (upd_taken) begin
                        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                        m_tgt[i] = upd_target;
                    end else begin
                        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                    end
                end else if (upd_taken) begin
                    m_valid[i] = 1'b1;
                    m_tag[i]   = tag_of(upd_pc);
                    m_tgt[i]   = upd_target;
                    m_ctr[i]   = 2;
                end
            end
        end
    endtask

    task automatic step_adv();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit rst, input bit dv, input bit miss, input bit stl,
                          input bit rdv, input logic [31:0] rpc,
                          input bit uv, input logic [31:0] upc, input logic [31:0] utg,
                          input bit ut);
        rst_n          = rst;
        data_valid     = dv;
        cache_miss     = miss;
        stall          = stl;
        redirect_valid = rdv;
        redirect_pc    = rpc;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_target     = utg;
        upd_taken      = ut;
    endtask

    logic [31:0] rtab [7] = '{32'h20, 32'h1C, 32'h120, 32'h40, 32'hFFFF_FFF8, 32'h3C, 32'h100};
    logic [31:0] utab [5] = '{32'h20, 32'h120, 32'h40, 32'h24, 32'h28};
    logic [31:0] ttab [5] = '{32'h100, 32'h200, 32'h20, 32'h40, 32'hFFFF_FFF8};

    initial begin
        bit resp_due;
        int miss_cnt;
        for (int k = 0; k < int'(NE); k++) begin
            m_valid[k] = 1'b0;
            m_tag[k]   = '0;
            m_tgt[k]   = '0;
            m_ctr[k]   = 0;
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step_adv();

        // Held in reset: a redirect must not raise req_kill
        set_in(0, 0, 0, 0, 1, 32'h40, 0, 0, 0, 0);
        step_check();
        chk("lit_rst_req_valid", 32'(req_valid), 32'd0);
        chk("lit_rst_req_kill",  32'(req_kill),  32'd0);
        chk("lit_rst_address",   address,        RV);
        chk("lit_rst_pred",      predicted_next_adr, 32'd0);
        step_adv();

        // Sequential fetch from the reset vector
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step_check(); chk("lit_a_addr", address, 32'h0); chk("lit_a_rv", 32'(req_valid), 32'd1); step_adv();
        step_check(); chk("lit_b_addr", address, 32'h4); chk("lit_b_pred", predicted_next_adr, 32'h4); step_adv();
        step_check(); chk("lit_c_addr", address, 32'h8); chk("lit_c_pred", predicted_next_adr, 32'h8); step_adv();

        // Miss on the 0x8 response; stall during the wait is ignored
        set_in(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step_check(); chk("lit_miss_rv", 32'(req_valid), 32'd0); chk("lit_miss_addr", address, 32'hC); step_adv();
        set_in(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        step_check(); chk("lit_wait_rv0", 32'(req_valid), 32'd0); step_adv();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step_check(); chk("lit_wait_rv1", 32'(req_valid), 32'd0); step_adv();
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step_check(); chk("lit_wait_dv_rv", 32'(req_valid), 32'd0); step_adv();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step_check(); chk("lit_resume_addr", address, 32'hC); chk("lit_resume_rv", 32'(req_valid), 32'd1); step_adv();

        // Three stall cycles at 0x10
        set_in(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step_check(); chk("lit_stall_rv", 32'(req_valid), 32'd0); chk("lit_stall_addr", address, 32'h10); step_adv();
        end
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step_check(); chk("lit_unstall_rv", 32'(req_valid), 32'd1); chk("lit_unstall_addr", address, 32'h10); step_adv();

        // Train 0x20 -> 0x100 taken, then follow the prediction
        set_in(1, 0, 0, 0, 0, 0, 1, 32'h20, 32'h100, 1);
        step_check(); step_adv();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step_check(); step_adv();
        step_check(); step_adv();
        step_check(); chk("lit_br_addr", address, 32'h20); step_adv();
        set_in(1, 0, 0, 0, 0, 0, 1, 32'h20, 32'h0, 0);
        step_check();
        chk("lit_br_pred", predicted_next_adr, 32'h100);
        chk("lit_br_bj",   32'(branch_jump),   32'd1);
        chk("lit_br_tgt",  address,            32'h100);
        step_adv();
        step_check(); step_adv();
        set_in(1, 0, 0, 0, 1, 32'h20, 0, 0, 0, 0);
        step_check(); chk("lit_redir_kill", 32'(req_kill), 32'd1); step_adv();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step_check(); chk("lit_nt_addr", address, 32'h20); step_adv();

        // Redirect beats miss and stall
        set_in(1, 0, 1, 1, 1, 32'h400, 0, 0, 0, 0);
        step_check();
        chk("lit_nt_pred", predicted_next_adr, 32'h24);
        chk("lit_nt_bj",   32'(branch_jump),   32'd0);
        chk("lit_rdm_kill", 32'(req_kill), 32'd1);
        chk("lit_rdm_rv",   32'(req_valid), 32'd0);
        step_adv();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step_check(); chk("lit_rdm_addr", address, 32'h400); chk("lit_rdm_rv1", 32'(req_valid), 32'd1); step_adv();

        // Wrap past the top of the address space, then reset mid-miss
        set_in(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        step_check(); step_adv();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step_check(); chk("lit_top_addr", address, 32'hFFFF_FFFC); step_adv();
        set_in(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step_check(); chk("lit_wrap_addr", address, 32'h0); chk("lit_wrap_pred", predicted_next_adr, 32'h0); step_adv();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step_check(); chk("lit_rstw_rv", 32'(req_valid), 32'd0); step_adv();
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step_check(); chk("lit_rstw_addr", address, RV); chk("lit_rstw_rv1", 32'(req_valid), 32'd1); step_adv();

        // Randomized traffic with a simple cache responder
        resp_due = 1'b0;
        miss_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            rst_n      = ($urandom_range(0, 99) != 0);
            data_valid = 1'b0;
            cache_miss = 1'b0;
            if (resp_due) begin
                if ($urandom_range(0, 3) == 0) begin
                    cache_miss = 1'b1;
                    miss_cnt   = $urandom_range(1, 4);
                end else begin
                    data_valid = 1'b1;
                end
            end else if (miss_cnt > 0) begin
                miss_cnt--;
                if (miss_cnt == 0) data_valid = 1'b1;
            end
            stall          = ($urandom_range(0, 4) == 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = rtab[$urandom_range(0, 6)];
            upd_valid      = ($urandom_range(0, 3) == 0);
            upd_pc         = utab[$urandom_range(0, 4)];
            upd_target     = ttab[$urandom_range(0, 4)];
            upd_taken      = ($urandom_range(0, 2) != 0);
            step_check();
            resp_due = e_rv;
            if (redirect_valid || !rst_n) miss_cnt = 0;
            step_adv();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
